regfile_alu_pipe: RTL and testbench

- Parametrised register-bank + ALU execute unit with one registered execute stage, write-back and operand bypass; next generation of the combinational bank/ALU pairing in the processor top.
- Owns general registers, dedicated stack pointer (push/pop) and JAL link write.
- Sits between decode (drives indices/ops) and the memory/PC logic (consumes result, zero flag, SP).

---
 rtl/regfile_alu_pkg.sv | 37 +++
 rtl/regfile_alu_pipe_if.sv | 46 ++++
 rtl/alu_core.sv | 48 ++++
 rtl/regfile_alu_pipe.sv | 152 +++++++++++++++
 tb/tb_regfile_alu_pipe.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_alu_pkg
// Description : Shared types for the register-bank / ALU execute unit:
//               ALU operation codes, stack operation codes, default SP step.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_alu_pkg;

   // ALU operation codes; codes 12..15 are undefined and yield a zero result
   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_NOR   = 4'd5,
      ALU_SLT   = 4'd6,
      ALU_SLTU  = 4'd7,
      ALU_SLL   = 4'd8,
      ALU_SRL   = 4'd9,
      ALU_SRA   = 4'd10,
      ALU_PASSB = 4'd11
   } alu_op_e;

   // Stack pointer adjustment requested by the issuing instruction
   typedef enum logic [1:0] {
      STK_NONE = 2'b00,
      STK_PUSH = 2'b01,
      STK_POP  = 2'b10,
      STK_RSVD = 2'b11
   } stack_op_e;

   localparam int SP_STEP_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/regfile_alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_alu_pipe_if
// Description : Issue/result bundle between decode (master) and the
//               register-bank / ALU execute unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_alu_pipe_if
   import regfile_alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
);
   localparam int AW = $clog2(NREG);

   // issue side
   logic              in_valid;
   alu_op_e           alu_op;
   logic [AW-1:0]     rs;
   logic [AW-1:0]     rt;
   logic [AW-1:0]     rd;
   logic              reg_write;
   stack_op_e         stack_op;
   logic              jal;
   logic [DATA_W-1:0] link_addr;

   // result side
   logic [DATA_W-1:0] dado1;
   logic [DATA_W-1:0] dado2;
   logic              out_valid;
   logic [DATA_W-1:0] ula_res;
   logic              zero;
   logic [DATA_W-1:0] sp_out;

   modport master (
      output in_valid, alu_op, rs, rt, rd, reg_write, stack_op, jal, link_addr,
      input  dado1, dado2, out_valid, ula_res, zero, sp_out
   );

   modport slave (
      input  in_valid, alu_op, rs, rt, rd, reg_write, stack_op, jal, link_addr,
      output dado1, dado2, out_valid, ula_res, zero, sp_out
   );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational ALU. Add/sub wrap silently; shifts use the low
//               $clog2(DATA_W) bits of Y; undefined op codes give zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
   import regfile_alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  alu_op_e           i_op,
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_y,
   output logic [DATA_W-1:0] o_result,
   output logic              o_zero
);
   localparam int SHW = $clog2(DATA_W);

   logic [SHW-1:0] w_shamt;

   assign w_shamt = i_y[SHW-1:0];

   // operation select
   always_comb begin
      o_result = '0;
      case (i_op)
         ALU_ADD:   o_result = i_x + i_y;
         ALU_SUB:   o_result = i_x - i_y;
         ALU_AND:   o_result = i_x & i_y;
         ALU_OR:    o_result = i_x | i_y;
         ALU_XOR:   o_result = i_x ^ i_y;
         ALU_NOR:   o_result = ~(i_x | i_y);
         ALU_SLT:   o_result = {{(DATA_W-1){1'b0}}, ($signed(i_x) < $signed(i_y))};
         ALU_SLTU:  o_result = {{(DATA_W-1){1'b0}}, (i_x < i_y)};
         ALU_SLL:   o_result = i_x << w_shamt;
         ALU_SRL:   o_result = i_x >> w_shamt;
         ALU_SRA:   o_result = $unsigned($signed(i_x) >>> w_shamt);
         ALU_PASSB: o_result = i_y;
         default:   o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/regfile_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : regfile_alu_pipe
// Description : General register bank with dedicated stack pointer, one
//               registered execute stage, write-back and EX->issue bypass.
//               Operands are read combinationally in the issue cycle; the
//               result appears one cycle later and retires on the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_alu_pipe
   import regfile_alu_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter int          NREG     = 32,
   parameter int          SP_IDX   = 29,
   parameter int          RA_IDX   = 31,
   parameter logic [31:0] SP_RESET = 32'h0000_03FC,
   parameter int          SP_STEP  = SP_STEP_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   regfile_alu_pipe_if.slave bus
);
   localparam int                AW         = $clog2(NREG);
   localparam logic [AW-1:0]     C_SP_IDX   = AW'(SP_IDX);
   localparam logic [AW-1:0]     C_RA_IDX   = AW'(RA_IDX);
   localparam logic [DATA_W-1:0] C_SP_RESET = DATA_W'(SP_RESET);
   localparam logic [DATA_W-1:0] C_SP_STEP  = DATA_W'(SP_STEP);

   // architectural state (the SP_IDX slot of the array is unused; SP lives in sp_q)
   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [DATA_W-1:0] sp_q, sp_d;

   // EX register: the instruction awaiting write-back
   logic              ex_valid_q, ex_valid_d;
   logic              ex_we_q,    ex_we_d;
   logic [AW-1:0]     ex_rd_q,    ex_rd_d;
   logic [DATA_W-1:0] ex_wdata_q, ex_wdata_d;
   logic [DATA_W-1:0] ula_res_q,  ula_res_d;
   logic              zero_q,     zero_d;

   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_alu_zero;
   logic [AW-1:0]     w_dest;
   logic              w_wb_sp;
   logic [DATA_W-1:0] w_sp_base;

   // operand A: zero register, then SP, then in-flight EX value, then array
   always_comb begin
      if (bus.rs == '0)
         w_op_a = '0;
      else if (bus.rs == C_SP_IDX)
         w_op_a = sp_q;
      else if (ex_we_q && (ex_rd_q == bus.rs))
         w_op_a = ex_wdata_q;
      else
         w_op_a = regs_q[bus.rs];
   end

   // operand B: same priority as operand A
   always_comb begin
      if (bus.rt == '0)
         w_op_b = '0;
      else if (bus.rt == C_SP_IDX)
         w_op_b = sp_q;
      else if (ex_we_q && (ex_rd_q == bus.rt))
         w_op_b = ex_wdata_q;
      else
         w_op_b = regs_q[bus.rt];
   end

   alu_core #(
      .DATA_W (DATA_W)
   ) u_alu_core (
      .i_op     (bus.alu_op),
      .i_x      (w_op_a),
      .i_y      (w_op_b),
      .o_result (w_alu_res),
      .o_zero   (w_alu_zero)
   );

   // EX register next state; a bubble holds the visible result and writes nothing
   always_comb begin
      w_dest     = bus.jal ? C_RA_IDX : bus.rd;
      ex_valid_d = bus.in_valid;
      ex_we_d    = bus.in_valid && (bus.reg_write || bus.jal) && (w_dest != '0);
      ex_rd_d    = w_dest;
      ex_wdata_d = bus.jal ? bus.link_addr : w_alu_res;
      ula_res_d  = ula_res_q;
      zero_d     = zero_q;
      if (bus.in_valid) begin
         ula_res_d = w_alu_res;
         zero_d    = w_alu_zero;
      end
   end

   // write-back into the array; SP_IDX writes are routed to the SP register instead
   always_comb begin
      regs_d = regs_q;
      if (ex_we_q && (ex_rd_q != C_SP_IDX))
         regs_d[ex_rd_q] = ex_wdata_q;
   end

   // SP: a same-edge write-back forms the base that push/pop adjusts
   always_comb begin
      w_wb_sp   = ex_we_q && (ex_rd_q == C_SP_IDX);
      w_sp_base = w_wb_sp ? ex_wdata_q : sp_q;
      sp_d      = w_sp_base;
      if (bus.in_valid) begin
         if (bus.stack_op == STK_PUSH)
            sp_d = w_sp_base - C_SP_STEP;
         else if (bus.stack_op == STK_POP)
            sp_d = w_sp_base + C_SP_STEP;
      end
   end

   // state registers with synchronous reset; reset discards the EX instruction
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs_q[i] <= '0;
         sp_q       <= C_SP_RESET;
         ex_valid_q <= 1'b0;
         ex_we_q    <= 1'b0;
         ex_rd_q    <= '0;
         ex_wdata_q <= '0;
         ula_res_q  <= '0;
         zero_q     <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         sp_q       <= sp_d;
         ex_valid_q <= ex_valid_d;
         ex_we_q    <= ex_we_d;
         ex_rd_q    <= ex_rd_d;
         ex_wdata_q <= ex_wdata_d;
         ula_res_q  <= ula_res_d;
         zero_q     <= zero_d;
      end
   end

   assign bus.dado1     = w_op_a;
   assign bus.dado2     = w_op_b;
   assign bus.out_valid = ex_valid_q;
   assign bus.ula_res   = ula_res_q;
   assign bus.zero      = zero_q;
   assign bus.sp_out    = sp_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_alu_pipe
// Description : Directed self-checking bench for regfile_alu_pipe. Expected
//               ALU results are queued at issue and popped when out_valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_alu_pipe;
   import regfile_alu_pkg::*;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   regfile_alu_pipe_if #(.DATA_W(32), .NREG(32)) bus ();

   regfile_alu_pipe #(
      .DATA_W   (32),
      .NREG     (32),
      .SP_IDX   (29),
      .RA_IDX   (31),
      .SP_RESET (32'h0000_03FC),
      .SP_STEP  (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
   } exp_t;

   exp_t sb_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one issue cycle: drive, check bypassed operands, clock, check results
   task automatic step(input string name, input bit v, input logic [3:0] op,
                       input int a, input int b, input int d, input bit rw,
                       input logic [1:0] stk, input bit j, input logic [31:0] link,
                       input bit chk, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] eres, input logic [31:0] esp);
      exp_t e;
      exp_t got;
      @(negedge clock);
      reset         = 1'b0;
      bus.in_valid  = v;
      bus.alu_op    = alu_op_e'(op);
      bus.rs        = 5'(a);
      bus.rt        = 5'(b);
      bus.rd        = 5'(d);
      bus.reg_write = rw;
      bus.stack_op  = stack_op_e'(stk);
      bus.jal       = j;
      bus.link_addr = link;
      if (v) begin
         e.res  = eres;
         e.zero = (eres == 32'h0);
         sb_q.push_back(e);
      end
      #2;
      if (chk) begin
         check({name, ".dado1"}, bus.dado1, e1);
         check({name, ".dado2"}, bus.dado2, e2);
      end
      @(posedge clock);
      #1;
      check({name, ".out_valid"}, 32'(bus.out_valid), 32'(v));
      if (bus.out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL %s.scoreboard observed=out_valid expected=empty_queue", name);
         end else begin
            got = sb_q.pop_front();
            check({name, ".ula_res"}, bus.ula_res, got.res);
            check({name, ".zero"}, 32'(bus.zero), 32'(got.zero));
         end
      end
      check({name, ".sp_out"}, bus.sp_out, esp);
   endtask

   task automatic do_reset(input string name);
      @(negedge clock);
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clock);
      #1;
      check({name, ".out_valid"}, 32'(bus.out_valid), 32'h0);
      check({name, ".ula_res"}, bus.ula_res, 32'h0);
      check({name, ".zero"}, 32'(bus.zero), 32'h0);
      check({name, ".sp_out"}, bus.sp_out, 32'h0000_03FC);
      sb_q.delete();
   endtask

   // watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.alu_op    = ALU_ADD;
      bus.rs        = '0;
      bus.rt        = '0;
      bus.rd        = '0;
      bus.reg_write = 1'b0;
      bus.stack_op  = STK_NONE;
      bus.jal       = 1'b0;
      bus.link_addr = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst.out_valid", 32'(bus.out_valid), 32'h0);
      check("rst.ula_res", bus.ula_res, 32'h0);
      check("rst.zero", 32'(bus.zero), 32'h0);
      check("rst.sp_out", bus.sp_out, 32'h0000_03FC);

      //   name          v op  rs rt rd rw stk j link           chk e1            e2            eres          esp
      step("s01_rd_sp",  0, 0, 29, 0, 0, 0, 0, 0, 0,            1, 32'h3FC,      0,            0,            32'h3FC);
      step("s02_add",    1, 0,  0, 0, 3, 1, 0, 0, 0,            1, 0,            0,            0,            32'h3FC);
      step("s03_jal7",   1, 0,  0, 0, 0, 0, 0, 1, 7,            1, 0,            0,            0,            32'h3FC);
      step("s04_passb",  1, 11, 0,31, 3, 1, 0, 0, 0,            1, 0,            7,            7,            32'h3FC);
      step("s05_sub",    1, 1,  3, 3, 4, 1, 0, 0, 0,            1, 7,            7,            0,            32'h3FC);
      step("s06_bubble", 0, 0,  4, 3, 0, 0, 0, 0, 0,            1, 0,            7,            0,            32'h3FC);
      step("s07_and",    1, 2,  3,31, 6, 1, 0, 0, 0,            1, 7,            7,            7,            32'h3FC);
      step("s08_push",   1, 0, 29, 0, 0, 0, 1, 0, 0,            1, 32'h3FC,      0,            32'h3FC,      32'h3F8);
      step("s09_push",   1, 0, 29, 0, 0, 0, 1, 0, 0,            1, 32'h3F8,      0,            32'h3F8,      32'h3F4);
      step("s10_pop",    1, 0, 29, 0, 0, 0, 2, 0, 0,            1, 32'h3F4,      0,            32'h3F4,      32'h3F8);
      step("s11_jal40",  1, 0,  0, 0, 5, 0, 0, 1, 32'h40,       0, 0,            0,            0,            32'h3F8);
      step("s12_rabyp",  0, 0, 31, 5, 0, 0, 0, 0, 0,            1, 32'h40,       0,            0,            32'h3F8);
      step("s13_raarr",  0, 0, 31, 5, 0, 0, 0, 0, 0,            1, 32'h40,       0,            0,            32'h3F8);
      step("s14_jal5",   1, 0,  0, 0, 0, 0, 0, 1, 5,            0, 0,            0,            0,            32'h3F8);
      step("s15_wr_r0",  1, 11, 0,31, 0, 1, 0, 0, 0,            1, 0,            5,            5,            32'h3F8);
      step("s16_rd_r0",  0, 0,  0, 0, 0, 0, 0, 0, 0,            1, 0,            0,            0,            32'h3F8);
      step("s17_rd_r0",  0, 0,  0,31, 0, 0, 0, 0, 0,            1, 0,            5,            0,            32'h3F8);
      step("s18_jal100", 1, 0,  0, 0, 0, 0, 0, 1, 32'h100,      0, 0,            0,            0,            32'h3F8);
      step("s19_wr_sp",  1, 11, 0,31,29, 1, 0, 0, 0,            1, 0,            32'h100,      32'h100,      32'h3F8);
      step("s20_wbpush", 1, 11, 0, 0, 0, 0, 1, 0, 0,            0, 0,            0,            0,            32'hFC);
      step("s21_jalfc",  1, 0,  0, 0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0,            0,            0,            32'hFC);
      step("s22_wr_sp",  1, 11, 0,31,29, 1, 0, 0, 0,            1, 0,            32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFC);
      step("s23_bubble", 0, 0,  0, 0, 0, 0, 0, 0, 0,            0, 0,            0,            0,            32'hFFFFFFFC);
      step("s24_popwrp", 1, 11, 0, 0, 0, 0, 2, 0, 0,            0, 0,            0,            0,            32'h0);
      step("s25_jal8",   1, 0,  0, 0, 0, 0, 0, 1, 32'h80000000, 0, 0,            0,            0,            32'h0);
      step("s26_r8",     1, 11, 0,31, 8, 1, 0, 0, 0,            1, 0,            32'h80000000, 32'h80000000, 32'h0);
      step("s27_jal4",   1, 0,  0, 0, 0, 0, 0, 1, 4,            0, 0,            0,            0,            32'h0);
      step("s28_sra",    1, 10, 8,31, 9, 1, 0, 0, 0,            1, 32'h80000000, 4,            32'hF8000000, 32'h0);
      step("s29_srl",    1, 9,  8,31,10, 1, 0, 0, 0,            1, 32'h80000000, 4,            32'h08000000, 32'h0);
      step("s30_sll",    1, 8, 31,31,11, 1, 0, 0, 0,            1, 4,            4,            32'h40,       32'h0);
      step("s31_slt",    1, 6,  8, 0, 7, 1, 0, 0, 0,            1, 32'h80000000, 0,            1,            32'h0);
      step("s32_sltu",   1, 7,  8, 0, 0, 0, 0, 0, 0,            0, 0,            0,            0,            32'h0);
      step("s33_nor",    1, 5,  0, 0, 0, 0, 0, 0, 0,            0, 0,            0,            32'hFFFFFFFF, 32'h0);
      step("s34_xor",    1, 4,  8,31, 0, 0, 0, 0, 0,            0, 0,            0,            32'h80000004, 32'h0);
      step("s35_or",     1, 3, 31, 8, 0, 0, 0, 0, 0,            0, 0,            0,            32'h80000004, 32'h0);
      step("s36_undef",  1, 12, 8,31, 0, 0, 0, 0, 0,            0, 0,            0,            0,            32'h0);
      step("s37_subwr",  1, 1,  0,31, 0, 0, 0, 0, 0,            0, 0,            0,            32'hFFFFFFFC, 32'h0);
      step("s38_wr_r5",  1, 11, 0,31, 5, 1, 0, 0, 0,            1, 0,            4,            4,            32'h0);
      do_reset("s39_rst");
      step("s40_rd_r5",  0, 0,  5,29, 0, 0, 0, 0, 0,            1, 0,            32'h3FC,      0,            32'h3FC);

      check("end.sb_empty", 32'(sb_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
